// File: rtl/led_bin_sequencer.sv
// Expands one frame of per-bin LED counts into an ordered stream of exactly LEDS
// strip entries (LED index, owning bin, lit flag) over a valid/ready handshake.
module led_bin_sequencer #(
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12,
    parameter int CW      = $clog2(LEDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BIN_QTY*CW-1:0]        LEDCount_i,
    input  logic                         data_v_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [CW-1:0]                ledIdx_o,
    output logic [$clog2(BIN_QTY)-1:0]   binIdx_o,
    output logic                         lit_o,
    output logic                         last_o,
    output logic                         busy_o,
    output logic                         frameDone_o,
    output logic                         trunc_o,
    output logic                         overrun_o
);

    localparam int BW = $clog2(BIN_QTY);
    localparam int PW = $clog2(BIN_QTY + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(LEDS - 1);
    localparam logic [PW-1:0] BIN_END  = PW'(BIN_QTY);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, nxt_state;
    logic [CW-1:0]   counts [BIN_QTY];
    logic [PW-1:0]   bin_ptr, nxt_bin_ptr;
    logic [CW-1:0]   remaining, nxt_remaining;
    logic [CW-1:0]   led_idx, nxt_led_idx;
    logic            nxt_trunc;
    logic            capture;
    logic            lit_mode;
    logic            emitting;
    logic            xfer;
    logic            later_nz;
    logic [CW-1:0]   next_count;
    logic            nxt_valid;
    logic            nxt_lit;

    // A bin pointer equal to BIN_END means every bin is spent and only filler remains.
    assign lit_mode = (bin_ptr != BIN_END);
    assign emitting = !lit_mode || (remaining != '0);
    assign xfer     = valid_o && ready_i;

    // NOTE: every value written here gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_state     = state;
        nxt_bin_ptr   = bin_ptr;
        nxt_remaining = remaining;
        nxt_led_idx   = led_idx;
        nxt_trunc     = trunc_o;
        capture       = 1'b0;
        later_nz      = 1'b0;
        next_count    = '0;

        for (int k = 0; k < BIN_QTY; k++) begin
            if (PW'(k) > bin_ptr && counts[k] != '0)
                later_nz = 1'b1;
            if (PW'(k) == bin_ptr + PW'(1))
                next_count = counts[k];
        end

        unique case (state)
            IDLE: begin
                if (data_v_i) begin
                    capture       = 1'b1;
                    nxt_state     = RUN;
                    nxt_bin_ptr   = '0;
                    nxt_remaining = LEDCount_i[CW-1:0];
                    nxt_led_idx   = '0;
                    nxt_trunc     = 1'b0;
                end
            end
            RUN: begin
                if (!emitting) begin
                    // Empty bin: spend one idle cycle stepping past it.
                    nxt_bin_ptr   = bin_ptr + PW'(1);
                    nxt_remaining = next_count;
                end else if (xfer) begin
                    if (led_idx == LAST_IDX) begin
                        nxt_state = DONE;
                        if (lit_mode && (remaining > CW'(1) || later_nz))
                            nxt_trunc = 1'b1;
                    end else begin
                        nxt_led_idx = led_idx + CW'(1);
                        if (lit_mode) begin
                            // Step to the next bin on the final count so full bins run back-to-back.
                            if (remaining == CW'(1)) begin
                                nxt_bin_ptr   = bin_ptr + PW'(1);
                                nxt_remaining = next_count;
                            end else begin
                                nxt_remaining = remaining - CW'(1);
                            end
                        end
                    end
                end
            end
            DONE: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        nxt_valid = (nxt_state == RUN) && ((nxt_bin_ptr == BIN_END) || (nxt_remaining != '0));
        nxt_lit   = nxt_valid && (nxt_bin_ptr != BIN_END);
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bin_ptr     <= '0;
            remaining   <= '0;
            led_idx     <= '0;
            valid_o     <= 1'b0;
            ledIdx_o    <= '0;
            binIdx_o    <= '0;
            lit_o       <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
            frameDone_o <= 1'b0;
            trunc_o     <= 1'b0;
            overrun_o   <= 1'b0;
            // NOTE: the count array is tiny, so it is cleared too and never carries stale bins.
            for (int k = 0; k < BIN_QTY; k++)
                counts[k] <= '0;
        end else begin
            state     <= nxt_state;
            bin_ptr   <= nxt_bin_ptr;
            remaining <= nxt_remaining;
            led_idx   <= nxt_led_idx;
            trunc_o   <= nxt_trunc;
            if (capture) begin
                for (int k = 0; k < BIN_QTY; k++)
                    counts[k] <= LEDCount_i[k*CW +: CW];
            end
            valid_o     <= nxt_valid;
            ledIdx_o    <= nxt_valid ? nxt_led_idx : '0;
            binIdx_o    <= nxt_lit ? nxt_bin_ptr[BW-1:0] : '0;
            lit_o       <= nxt_lit;
            last_o      <= nxt_valid && (nxt_led_idx == LAST_IDX);
            busy_o      <= (nxt_state != IDLE);
            frameDone_o <= (nxt_state == DONE);
            overrun_o   <= data_v_i && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_led_bin_sequencer.sv
// Randomised bench for led_bin_sequencer: each frame's stream is compared with a
// slot-filling model of the strip built from the captured counts.
module tb_led_bin_sequencer;

    localparam int LEDS    = 50;
    localparam int BIN_QTY = 12;
    localparam int CW      = $clog2(LEDS);
    localparam int BW      = $clog2(BIN_QTY);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [BIN_QTY*CW-1:0] LEDCount_i;
    logic                  data_v_i;
    logic                  ready_i;
    logic                  valid_o;
    logic [CW-1:0]         ledIdx_o;
    logic [BW-1:0]         binIdx_o;
    logic                  lit_o;
    logic                  last_o;
    logic                  busy_o;
    logic                  frameDone_o;
    logic                  trunc_o;
    logic                  overrun_o;

    led_bin_sequencer #(.LEDS(LEDS), .BIN_QTY(BIN_QTY), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .LEDCount_i  (LEDCount_i),
        .data_v_i    (data_v_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .ledIdx_o    (ledIdx_o),
        .binIdx_o    (binIdx_o),
        .lit_o       (lit_o),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .frameDone_o (frameDone_o),
        .trunc_o     (trunc_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt [BIN_QTY];
    int exp_bin [LEDS];
    bit exp_lit [LEDS];
    bit exp_trunc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strip model: bins claim consecutive slots in order, leftovers are unlit, excess is dropped.
    function automatic void build_expected();
        int slot = 0;
        int total = 0;
        for (int i = 0; i < LEDS; i++) begin
            exp_bin[i] = 0;
            exp_lit[i] = 1'b0;
        end
        for (int b = 0; b < BIN_QTY; b++) begin
            total += cnt[b];
            for (int j = 0; j < cnt[b]; j++) begin
                if (slot < LEDS) begin
                    exp_bin[slot] = b;
                    exp_lit[slot] = 1'b1;
                    slot++;
                end
            end
        end
        exp_trunc = (total > LEDS);
    endfunction

    task automatic run_frame(input int pct, input int ovr_at, input int rst_at);
        int n = 0;
        int cyc = 0;
        bit prev_stall = 1'b0;
        bit prev_dv = 1'b0;
        bit inj = 1'b0;
        logic [CW-1:0] p_idx = '0;
        logic [BW-1:0] p_bin = '0;
        logic p_lit = 1'b0;
        logic p_last = 1'b0;

        build_expected();
        for (int k = 0; k < BIN_QTY; k++)
            LEDCount_i[k*CW +: CW] = CW'(cnt[k]);
        data_v_i = 1'b1;
        ready_i  = 1'b0;
        @(negedge clk);
        data_v_i = 1'b0;
        if (cnt[0] != 0)
            check("first_valid_latency", 32'(valid_o), 1);
        check("trunc_cleared_on_capture", 32'(trunc_o), 0);
        check("busy_after_capture", 32'(busy_o), 1);

        while (n < LEDS && cyc < 1000) begin
            prev_dv  = data_v_i;
            data_v_i = 1'b0;
            check("overrun_pulse", 32'(overrun_o), 32'(prev_dv));

            if (rst_at == n) begin
                rst     = 1'b1;
                ready_i = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check("rst_valid_low", 32'(valid_o), 0);
                check("rst_busy_low", 32'(busy_o), 0);
                check("rst_no_frame_done", 32'(frameDone_o), 0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_quiet_done", 32'(frameDone_o), 0);
                    check("rst_quiet_valid", 32'(valid_o), 0);
                end
                return;
            end

            if (prev_stall) begin
                check("stall_valid_held", 32'(valid_o), 1);
                check("stall_idx_stable", 32'(ledIdx_o), 32'(p_idx));
                check("stall_bin_stable", 32'(binIdx_o), 32'(p_bin));
                check("stall_lit_stable", 32'(lit_o), 32'(p_lit));
                check("stall_last_stable", 32'(last_o), 32'(p_last));
            end

            ready_i = (int'($urandom_range(0, 99)) < pct);
            if (valid_o && ready_i) begin
                check("led_idx", 32'(ledIdx_o), n);
                check("bin_idx", 32'(binIdx_o), exp_bin[n]);
                check("lit", 32'(lit_o), 32'(exp_lit[n]));
                check("last", 32'(last_o), 32'(n == LEDS - 1));
                n++;
            end
            prev_stall = valid_o && !ready_i;
            p_idx  = ledIdx_o;
            p_bin  = binIdx_o;
            p_lit  = lit_o;
            p_last = last_o;

            if (ovr_at == n && !inj) begin
                inj = 1'b1;
                data_v_i = 1'b1;
                for (int k = 0; k < BIN_QTY; k++)
                    LEDCount_i[k*CW +: CW] = CW'($urandom_range(0, 63));
            end
            @(negedge clk);
            cyc++;
        end

        if (n < LEDS) begin
            check("frame_timeout", 32'(n), LEDS);
            return;
        end
        ready_i = 1'b0;
        check("frame_done_pulse", 32'(frameDone_o), 1);
        check("busy_in_done", 32'(busy_o), 1);
        check("valid_low_in_done", 32'(valid_o), 0);
        check("trunc_flag", 32'(trunc_o), 32'(exp_trunc));
        @(negedge clk);
        check("frame_done_one_cycle", 32'(frameDone_o), 0);
        check("idle_not_busy", 32'(busy_o), 0);
        check("trunc_sticky", 32'(trunc_o), 32'(exp_trunc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        data_v_i   = 1'b0;
        ready_i    = 1'b0;
        LEDCount_i = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(valid_o), 0);
        check("reset_busy", 32'(busy_o), 0);
        check("reset_done", 32'(frameDone_o), 0);
        check("reset_trunc", 32'(trunc_o), 0);
        check("reset_overrun", 32'(overrun_o), 0);
        check("reset_lit", 32'(lit_o), 0);
        check("reset_last", 32'(last_o), 0);
        check("reset_idx", 32'(ledIdx_o), 0);
        rst = 1'b0;
        @(negedge clk);

        cnt = '{3, 0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 0};
        run_frame(100, -1, -1);
        for (int k = 0; k < BIN_QTY; k++) cnt[k] = 5;
        run_frame(100, -1, -1);
        for (int k = 0; k < BIN_QTY; k++) cnt[k] = 0;
        run_frame(100, -1, -1);
        cnt = '{3, 0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 0};
        run_frame(50, -1, -1);

        for (int k = 0; k < BIN_QTY; k++) cnt[k] = int'($urandom_range(0, 6));
        run_frame(100, 20, -1);
        run_frame(100, -1, -1);

        for (int k = 0; k < BIN_QTY; k++) cnt[k] = 2;
        run_frame(100, -1, 7);
        run_frame(70, -1, -1);

        repeat (8) begin
            int mode = int'($urandom_range(0, 2));
            for (int k = 0; k < BIN_QTY; k++) begin
                if (mode == 0)
                    cnt[k] = int'($urandom_range(0, 3));
                else if (mode == 1)
                    cnt[k] = int'($urandom_range(0, 8));
                else
                    cnt[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 0;
            end
            run_frame(int'($urandom_range(30, 100)), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_bin_sequencer.md
Name: led_bin_sequencer

Overview:
- Downstream of LEDCountCalc.
- Takes the per-bin LED counts (one frame per data_v pulse) and expands them into a serial stream of exactly LEDS entries.
- Each entry carries the LED index, the owning note bin and a lit flag.
- The stream feeds the colour/pixel driver through a valid/ready handshake. Frames are sequenced so the driver always receives a complete, ordered strip image.

Parameters:
LEDS, 50, number of physical LEDs on the strip
BIN_QTY, 12, number of note bins
CW, $clog2(LEDS), width of each per-bin count (matches LEDCountCalc LEDCount element)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
LEDCount_i  in  BIN_QTY*CW  packed per-bin LED counts, element [k] = bin k
data_v_i  in  1  single-cycle pulse: LEDCount_i valid this cycle
ready_i  in  1  downstream accepts current entry
valid_o  out  1  entry valid
ledIdx_o  out  CW  LED index 0..LEDS-1
binIdx_o  out  $clog2(BIN_QTY)  owning bin (0 when lit_o=0)
lit_o  out  1  1 = LED assigned to binIdx_o, 0 = unlit filler
last_o  out  1  asserted with the entry whose ledIdx_o = LEDS-1
busy_o  out  1  frame in progress (state != IDLE)
frameDone_o  out  1  one-cycle pulse, the cycle after the last handshake
trunc_o  out  1  sticky per frame: counts summed above LEDS; cleared on next capture
overrun_o  out  1  one-cycle pulse: data_v_i arrived while busy_o=1

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Internal count registers clear.
  - Reset mid-frame abandons the frame with no last_o and no frameDone_o.
- Handshake:
  - A transfer occurs when valid_o & ready_i are both high at a clk edge.
  - Once valid_o is asserted, the payload (ledIdx_o, binIdx_o, lit_o, last_o) holds stable and valid_o holds high until the transfer.
  - valid_o never depends combinationally on ready_i.
- IDLE state:
  - data_v_i=1 latches LEDCount_i into a local array.
  - binPtr := 0, remaining := LEDCount_i[0], ledIdx := 0, trunc_o := 0.
  - Next state is RUN.
  - data_v_i while not IDLE: the capture is ignored and overrun_o pulses for 1 cycle. The current frame is unaffected.
- RUN state, binPtr width $clog2(BIN_QTY+1):
  - binPtr < BIN_QTY and remaining == 0: binPtr++ and load remaining from the next bin. This is a skip cycle with valid_o=0, costing one cycle per empty bin.
  - binPtr < BIN_QTY and remaining > 0: valid_o=1, lit_o=1, binIdx_o=binPtr. On transfer: remaining--, ledIdx++.
  - binPtr == BIN_QTY (bins exhausted): valid_o=1, lit_o=0, binIdx_o=0. On transfer: ledIdx++.
  - Truncation: if a transfer occurs at ledIdx == LEDS-1 while remaining-after-decrement > 0, or while any later bin is nonzero, trunc_o := 1. Excess counts are dropped.
  - Transfer at ledIdx == LEDS-1 (last_o=1): next state is DONE.
- DONE state: frameDone_o=1 for one cycle, then IDLE. A data_v_i in DONE counts as busy and is flagged by overrun_o.
- Latency:
  - Capture at edge N gives the earliest valid_o at cycle N+1 (when LEDCount[0] > 0).
  - Under continuous ready, throughput is 1 LED/cycle, plus 1 cycle per zero-count bin crossed.
- Counts are unsigned. The sum is not precomputed; truncation is detected during the walk.

Test Plan:
1. Counts [3,0,0,0,0,1,3,0,3,0,0,0], ready_i=1 -> 3×bin0, 1×bin5, 3×bin6, 3×bin8 lit (idx 0..9), then idx 10..49 lit_o=0. last_o on idx 49, frameDone_o next cycle, trunc_o=0.
2. All counts 5 (sum 60) -> bins 0..9 fill idx 0..49, bins 10/11 never emitted, trunc_o=1 after the last transfer.
3. All counts 0 -> 50 entries with lit_o=0, binIdx_o=0, last_o on idx 49.
4. Case 1 with ready_i random 50% -> identical entry sequence; payload stable whenever valid_o=1 & ready_i=0.
5. data_v_i pulsed at idx 20 of a frame -> overrun_o 1-cycle pulse, stream unchanged; data_v_i after frameDone_o starts a new frame at idx 0.
6. rst asserted at idx 7 -> next cycle valid_o=0, busy_o=0, no frameDone_o; a new data_v_i restarts at idx 0.
